irq_ctrl: RTL

- Programmable interrupt controller between the bridge-attached timers/devices and the CPU's HWInt[7:2] input.
- Latches device IRQ lines into a pending register and applies per-source mask and edge/level mode.
- Selects one active source by fixed priority, presents it one-hot to the CPU, and holds it until software writes an end-of-interrupt (EOI).
- Mapped behind the bridge as one more device with four word registers.

---
 rtl/irq_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: programmable interrupt controller feeding the CPU HWInt lines
// Ports: clk, reset (async, active-high); bridge side addr/we/wd/rd with
//   MASK 0x0, MODE 0x4, PEND 0x8 (W1C, edge bits), STAT 0xC (read status, write EOI);
//   irq_in raw device lines, hwint one-hot active source, irq_any OR of hwint.
// Build option IRQ_CTRL_SYNC_EN: adds a 2-flop input synchronizer ahead of edge detect.
module irq_ctrl #(
  parameter int NSRC = 6,
  parameter logic [5:0] RST_MASK = 6'b000000,
  parameter logic [5:0] RST_MODE = 6'b000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     addr,
  input  logic            we,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  input  logic [NSRC-1:0] irq_in,
  output logic [NSRC-1:0] hwint,
  output logic            irq_any
);
  typedef enum logic {IDLE, ASSERT} state_t;
  state_t state;
  logic [NSRC-1:0] mask, mode, pend, irq_s, irq_d, rise, clr, elig, pend_nxt;
  logic [2:0] active_id, lo;
  logic [1:0] sel;
  logic eoi;
  logic unused;
`ifdef IRQ_CTRL_SYNC_EN
  logic [NSRC-1:0] sync1;
  always_ff @(posedge clk or posedge reset)
    if (reset) {irq_s, sync1} <= '0;
    else {irq_s, sync1} <= {sync1, irq_in};
`else
  assign irq_s = irq_in;
`endif
  assign sel = addr[3:2];
  assign unused = ^{addr[31:4], addr[1:0], wd};
  assign rise = irq_s & ~irq_d;
  assign elig = pend & mask;
  assign eoi = we && sel == 2'd3 && state == ASSERT && wd[2:0] == active_id;
  // software W1C and a matching EOI both clear; only edge bits honour it
  assign clr = ({NSRC{we && sel == 2'd2}} & wd[NSRC-1:0]) | ({NSRC{eoi}} & (NSRC'(1) << active_id));
  // a rise in the same cycle as a clear keeps the bit set
  assign pend_nxt = (mode & ((pend & ~clr) | rise)) | (~mode & irq_s);
  assign rd = sel == 2'd0 ? 32'(mask) :
              sel == 2'd1 ? 32'(mode) :
              sel == 2'd2 ? 32'(pend) : {state == ASSERT, 28'b0, active_id};
  assign irq_any = |hwint;
  always_comb begin
    lo = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) lo = 3'(i);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      active_id <= '0;
      hwint <= '0;
      mask <= RST_MASK[NSRC-1:0];
      mode <= RST_MODE[NSRC-1:0];
      pend <= '0;
      irq_d <= '0;
    end else begin
      irq_d <= irq_s;
      pend <= pend_nxt;
      if (we && sel == 2'd0) mask <= wd[NSRC-1:0];
      if (we && sel == 2'd1) mode <= wd[NSRC-1:0];
      if (state == IDLE && |elig) begin
        state <= ASSERT;
        active_id <= lo;
        hwint <= NSRC'(1) << lo;
      end else if (eoi) begin
        state <= IDLE;
        hwint <= '0;
      end
    end
endmodule
